// File: rtl/pf_lanectrl_pause_pkg.sv
// pf_lanectrl_pause_pkg
// Shared widths and parameter limits for the lane-control pause block.
// Optional build macro: PF_LANECTRL_PAUSE_STATUS_EN (stretch-event counters).
package pf_lanectrl_pause_pkg;

  localparam int CNT_W         = 4;   // stretch counter width
  localparam int STAT_W        = 8;   // per-lane stretch-event counter width
  localparam int MAX_LANES     = 16;
  localparam int MAX_SYNC      = 4;
  localparam int MAX_MIN_PULSE = 15;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [STAT_W-1:0] stat_t;

  // Counter load value for a fresh rise: the rise cycle itself is the first
  // of the MIN_PULSE output cycles, so the counter covers the remaining ones.
  function automatic cnt_t stretch_reload(input int min_pulse);
    return cnt_t'(min_pulse - 1);
  endfunction

endpackage

// File: rtl/pf_lanectrl_pause_lane.sv
// pf_lanectrl_pause_lane
// One pause lane: synchroniser chain, rise/fall detect, minimum-width stretch
// counter, rising-edge output flop and optional falling-edge retiming flop.
// Optional build macro: PF_LANECTRL_PAUSE_STATUS_EN adds a saturating count of
// pulses that needed stretching.
// Ports:
//   CLK, RESET_N     lane-control clock, asynchronous active-low reset
//   pause_req        asynchronous pause request
//   status_clr       synchronous clear of the stretch-event count (macro only)
//   stretch_cnt      saturating stretch-event count (macro only)
//   pause_r          rising-edge registered pause (feeds the aggregate flags)
//   pause_sync       lane output (pause_r, or its falling-edge copy)
module pf_lanectrl_pause_lane
  import pf_lanectrl_pause_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter bit OUT_FALL    = 1'b0
) (
  input  logic  CLK,
  input  logic  RESET_N,
  input  logic  pause_req,
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
  input  logic  status_clr,
  output stat_t stretch_cnt,
`endif
  output logic  pause_r,
  output logic  pause_sync
);

  localparam cnt_t RELOAD = stretch_reload(MIN_PULSE);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_in;
  logic                   sync_d_reg;
  logic                   rise;
  cnt_t                   cnt_reg;
  cnt_t                   cnt_next;
  logic                   pause_reg;
  logic                   pause_next;

  // Synchroniser chain; stage 0 is the only flop seeing the async input.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= pause_req;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign sync_in = sync_reg[SYNC_STAGES-1];
  assign rise    = sync_in & ~sync_d_reg;

  // A rise always reloads, so a retrigger mid-stretch extends the pulse.
  always_comb begin
    cnt_next = cnt_reg;
    if (rise) begin
      cnt_next = RELOAD;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  assign pause_next = sync_in | (cnt_reg != '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_d_reg <= 1'b0;
      cnt_reg    <= '0;
      pause_reg  <= 1'b0;
    end else begin
      sync_d_reg <= sync_in;
      cnt_reg    <= cnt_next;
      pause_reg  <= pause_next;
    end
  end

  assign pause_r = pause_reg;

  generate
    if (OUT_FALL) begin : g_out_fall
      // Half-cycle retiming so the clock gate sees a change while CLK is low.
      logic fall_reg;
      always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          fall_reg <= 1'b0;
        end else begin
          fall_reg <= pause_reg;
        end
      end
      assign pause_sync = fall_reg;
    end else begin : g_out_rise
      assign pause_sync = pause_reg;
    end
  endgenerate

`ifdef PF_LANECTRL_PAUSE_STATUS_EN
  // A synchronised fall while the counter is still running means the request
  // was shorter than MIN_PULSE and the stretcher had to extend it.
  logic  fall;
  stat_t stat_reg;
  stat_t stat_next;

  assign fall = ~sync_in & sync_d_reg;

  always_comb begin
    stat_next = stat_reg;
    if (status_clr) begin
      stat_next = '0;
    end else if (fall && (cnt_reg != '0) && (stat_reg != '1)) begin
      stat_next = stat_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stat_reg <= '0;
    end else begin
      stat_reg <= stat_next;
    end
  end

  assign stretch_cnt = stat_reg;
`endif

endmodule

// File: rtl/pf_lanectrl_pause_ctrl.sv
// pf_lanectrl_pause_ctrl
// Multi-lane HS_IO_CLK_PAUSE synchroniser / pulse stretcher with aggregate
// all/any-paused flags for the training sequencer.
// Optional build macro: PF_LANECTRL_PAUSE_STATUS_EN adds STATUS_CLR and
// STRETCH_CNT (per-lane saturating stretch-event counts).
// Ports:
//   CLK                    lane-control clock
//   RESET_N                asynchronous active-low reset
//   HS_IO_CLK_PAUSE        per-lane asynchronous pause requests
//   STATUS_CLR             clear all stretch-event counts (macro only)
//   STRETCH_CNT            8 bits per lane, lane i at [8*i+:8] (macro only)
//   HS_IO_CLK_PAUSE_SYNC   per-lane synchronised, stretched pause
//   ALL_PAUSED/ANY_PAUSED  registered AND/OR of the lane pauses
module pf_lanectrl_pause_ctrl
  import pf_lanectrl_pause_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter bit OUT_FALL    = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [NUM_LANES-1:0]        HS_IO_CLK_PAUSE,
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
  input  logic                        STATUS_CLR,
  output logic [STAT_W*NUM_LANES-1:0] STRETCH_CNT,
`endif
  output logic [NUM_LANES-1:0]        HS_IO_CLK_PAUSE_SYNC,
  output logic                        ALL_PAUSED,
  output logic                        ANY_PAUSED
);

  generate
    if (NUM_LANES < 1 || NUM_LANES > MAX_LANES ||
        SYNC_STAGES < 1 || SYNC_STAGES > MAX_SYNC ||
        MIN_PULSE < 1 || MIN_PULSE > MAX_MIN_PULSE) begin : g_bad_param
      $error("pf_lanectrl_pause_ctrl: parameter out of range");
    end
  endgenerate

  logic [NUM_LANES-1:0] pause_r_vec;
  logic                 all_reg;
  logic                 any_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      pf_lanectrl_pause_lane #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_PULSE   (MIN_PULSE),
        .OUT_FALL    (OUT_FALL)
      ) u_lane (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .pause_req   (HS_IO_CLK_PAUSE[gi]),
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
        .status_clr  (STATUS_CLR),
        .stretch_cnt (STRETCH_CNT[STAT_W*gi +: STAT_W]),
`endif
        .pause_r     (pause_r_vec[gi]),
        .pause_sync  (HS_IO_CLK_PAUSE_SYNC[gi])
      );
    end
  endgenerate

  // Flags always come from the rising-edge flops so they stay in the CLK
  // rising domain even when lane outputs are retimed to the falling edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      all_reg <= 1'b0;
      any_reg <= 1'b0;
    end else begin
      all_reg <= &pause_r_vec;
      any_reg <= |pause_r_vec;
    end
  end

  assign ALL_PAUSED = all_reg;
  assign ANY_PAUSED = any_reg;

endmodule

// File: tb/tb_pf_lanectrl_pause_ctrl.sv
// tb_pf_lanectrl_pause_ctrl
// Directed bench for pf_lanectrl_pause_ctrl (4 lanes, 2 sync stages,
// MIN_PULSE=4, rising-edge output). A sliding-window model predicts each lane
// from the stretch rule: the output is high SYNC_STAGES+1 edges after an input
// sample was high, or within MIN_PULSE cycles of a synchronised rise.
module tb_pf_lanectrl_pause_ctrl;

  localparam int NL = 4;
  localparam int S  = 2;
  localparam int MP = 4;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic [NL-1:0]   HS_IO_CLK_PAUSE = '1;
  logic [NL-1:0]   HS_IO_CLK_PAUSE_SYNC;
  logic            ALL_PAUSED;
  logic            ANY_PAUSED;
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
  logic            STATUS_CLR = 1'b0;
  logic [8*NL-1:0] STRETCH_CNT;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  pf_lanectrl_pause_ctrl #(
    .NUM_LANES   (NL),
    .SYNC_STAGES (S),
    .MIN_PULSE   (MP),
    .OUT_FALL    (1'b0)
  ) dut (
    .CLK                  (CLK),
    .RESET_N              (RESET_N),
    .HS_IO_CLK_PAUSE      (HS_IO_CLK_PAUSE),
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
    .STATUS_CLR           (STATUS_CLR),
    .STRETCH_CNT          (STRETCH_CNT),
`endif
    .HS_IO_CLK_PAUSE_SYNC (HS_IO_CLK_PAUSE_SYNC),
    .ALL_PAUSED           (ALL_PAUSED),
    .ANY_PAUSED           (ANY_PAUSED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- model ----------------
  // xh[l][k] = input of lane l sampled k rising edges ago (0 = newest).
  bit [31:0] xh [NL];
  bit [NL-1:0] prev_out;

  function automatic bit [NL-1:0] model_out();
    bit [NL-1:0] o;
    o = '0;
    for (int l = 0; l < NL; l++) begin
      if (xh[l][S]) o[l] = 1'b1;
      for (int k = S; k < S + MP; k++)
        if (xh[l][k] && !xh[l][k+1]) o[l] = 1'b1;
    end
    return o;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int l = 0; l < NL; l++) xh[l] <= '0;
      prev_out <= '0;
    end else begin
      prev_out <= model_out();
      for (int l = 0; l < NL; l++) xh[l] <= {xh[l][30:0], HS_IO_CLK_PAUSE[l]};
    end
  end

  // One compare per falling edge, away from the active edge.
  always @(negedge CLK) begin
    chk("lane_out", 64'(HS_IO_CLK_PAUSE_SYNC), 64'(model_out()));
    chk("all_paused", 64'(ALL_PAUSED), 64'(&prev_out));
    chk("any_paused", 64'(ANY_PAUSED), 64'(|prev_out));
  end

  // Expected stretch-event counts, kept at pulse level (width < MP counts).
  int stat_exp [NL];

  function automatic logic [8*NL-1:0] stat_pack();
    logic [8*NL-1:0] v;
    for (int l = 0; l < NL; l++) v[8*l +: 8] = 8'(stat_exp[l]);
    return v;
  endfunction

  // Drive pattern bit c at falling edge c on the masked lanes, measuring the
  // selected lane output and ANY_PAUSED before each drive.
  task automatic play(input bit [63:0] pat, input logic [NL-1:0] mask, input int lane,
                      input int ncyc, output int hi, output int first,
                      output int runs, output int any_hi);
    logic prev;
    int   w;
    hi = 0; first = -1; runs = 0; any_hi = 0; prev = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      if (HS_IO_CLK_PAUSE_SYNC[lane]) begin
        hi++;
        if (first < 0) first = c;
        if (!prev) runs++;
      end
      prev = HS_IO_CLK_PAUSE_SYNC[lane];
      if (ANY_PAUSED) any_hi++;
      HS_IO_CLK_PAUSE = pat[c] ? mask : '0;
    end
    w = 0;
    for (int c = 0; c <= ncyc; c++) begin
      if (c < ncyc && pat[c]) w++;
      else begin
        if (w > 0 && w < MP)
          for (int l = 0; l < NL; l++)
            if (mask[l] && stat_exp[l] < 255) stat_exp[l]++;
        w = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, first, runs, any_hi, rise_e, all_e, found;
    for (int l = 0; l < NL; l++) stat_exp[l] = 0;

    // Reset with all requests high: outputs must read 0.
    repeat (4) @(negedge CLK);
    chk("rst_sync", 64'(HS_IO_CLK_PAUSE_SYNC), 64'h0);
    chk("rst_all", 64'(ALL_PAUSED), 64'h0);
    chk("rst_any", 64'(ANY_PAUSED), 64'h0);
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
    chk("rst_stat", 64'(STRETCH_CNT), 64'h0);
`endif

    // Release: lanes rise after 3 edges, ALL_PAUSED one edge later.
    @(negedge CLK);
    RESET_N = 1'b1;
    rise_e = -1; all_e = -1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge CLK); #1;
      if (rise_e < 0 && HS_IO_CLK_PAUSE_SYNC == 4'hF) rise_e = e;
      if (all_e < 0 && ALL_PAUSED) all_e = e;
    end
    chk("release_lat", 64'(rise_e), 64'd3);
    chk("release_all_lat", 64'(all_e), 64'd4);
    @(negedge CLK);
    HS_IO_CLK_PAUSE = '0;
    repeat (8) @(negedge CLK);

    // Short 1-cycle pulse on lane 2 -> 4 cycles high.
    play(64'h1, 4'b0100, 2, 16, hi, first, runs, any_hi);
    chk("short_width", 64'(hi), 64'd4);
    chk("short_lat", 64'(first), 64'd3);
    chk("short_runs", 64'(runs), 64'd1);
    chk("short_any", 64'(any_hi), 64'd4);
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
    chk("short_stat", 64'(STRETCH_CNT), 64'h0001_0000);
`endif

    // Long 10-cycle pulse on lane 1 -> 10 cycles, no count.
    play(64'h3FF, 4'b0010, 1, 20, hi, first, runs, any_hi);
    chk("long_width", 64'(hi), 64'd10);
    chk("long_lat", 64'(first), 64'd3);
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
    chk("long_stat", 64'(STRETCH_CNT), 64'(stat_pack()));
`endif

    // Retrigger: 1-cycle pulses 3 apart -> one contiguous 7-cycle output.
    play(64'h9, 4'b0100, 2, 20, hi, first, runs, any_hi);
    chk("retrig_width", 64'(hi), 64'd7);
    chk("retrig_runs", 64'(runs), 64'd1);
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
    chk("retrig_stat", 64'(STRETCH_CNT), 64'h0003_0000);
`endif

    // Two well-separated short pulses -> two separate 4-cycle outputs.
    play(64'h401, 4'b0001, 0, 24, hi, first, runs, any_hi);
    chk("sep_width", 64'(hi), 64'd8);
    chk("sep_runs", 64'(runs), 64'd2);

    // All lanes at once, 2-cycle pulse -> identical 4-cycle outputs.
    play(64'h3, 4'b1111, 3, 16, hi, first, runs, any_hi);
    chk("all_width", 64'(hi), 64'd4);
    chk("all_lat", 64'(first), 64'd3);
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
    chk("all_stat", 64'(STRETCH_CNT), 64'(stat_pack()));
`endif

    // Mid-stretch reset on lane 1.
    @(negedge CLK); HS_IO_CLK_PAUSE = 4'b0010;
    @(negedge CLK); HS_IO_CLK_PAUSE = '0;
    found = 0;
    for (int e = 0; e < 10 && !found; e++) begin
      @(posedge CLK); #1;
      if (HS_IO_CLK_PAUSE_SYNC[1]) found = 1;
    end
    chk("mid_rise_seen", 64'(found), 64'd1);
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1 chk("mid_rst_async", 64'({HS_IO_CLK_PAUSE_SYNC, ALL_PAUSED, ANY_PAUSED}), 64'h0);
    for (int l = 0; l < NL; l++) stat_exp[l] = 0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (HS_IO_CLK_PAUSE_SYNC != '0 || ANY_PAUSED) hi++;
    end
    chk("mid_rst_stays_low", 64'(hi), 64'd0);
`ifdef PF_LANECTRL_PAUSE_STATUS_EN
    chk("mid_rst_stat", 64'(STRETCH_CNT), 64'h0);

    // Saturation: 300 short pulses on lane 0.
    for (int p = 0; p < 300; p++) play(64'h1, 4'b0001, 0, 8, hi, first, runs, any_hi);
    chk("sat_model", 64'(stat_exp[0]), 64'd255);
    chk("sat_stat", 64'(STRETCH_CNT), 64'h0000_00FF);

    // Plain clear, then one counted pulse.
    @(negedge CLK); STATUS_CLR = 1'b1;
    @(negedge CLK); STATUS_CLR = 1'b0;
    for (int l = 0; l < NL; l++) stat_exp[l] = 0;
    chk("clr_stat", 64'(STRETCH_CNT), 64'h0);
    play(64'h1, 4'b0001, 0, 8, hi, first, runs, any_hi);
    chk("after_clr_stat", 64'(STRETCH_CNT), 64'h1);

    // Clear on the same edge as a stretch event: clear wins.
    @(negedge CLK); HS_IO_CLK_PAUSE = 4'b0001;
    @(negedge CLK); HS_IO_CLK_PAUSE = '0;
    @(negedge CLK);
    @(negedge CLK); STATUS_CLR = 1'b1;
    @(negedge CLK); STATUS_CLR = 1'b0;
    chk("clr_wins", 64'(STRETCH_CNT), 64'h0);
    repeat (6) @(negedge CLK);
    chk("clr_wins_hold", 64'(STRETCH_CNT), 64'h0);
`endif

    repeat (4) @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
